pad_window_sequencer: RTL and testbench

- Drive side of the 3-row padded column buffer. Reads a stored greyscale image from a synchronous single-port RAM and emits the (c, pix) beat stream that the column buffer consumes, producing one 24-bit window column per output position.
- Same-padding for a 3x3 convolution is generated here: zero pixels at the top and bottom rows, and a single c=11 clear beat for each left and right pad column.
- Sits between the frame RAM and the column buffer; the 3x3 MAC array downstream samples the buffer on col_valid.

---
 rtl/pad_window_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_pad_window_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pad_window_sequencer.sv
// Frame-RAM reader that emits the same-padded (c, pix) beat stream for a 3-row column buffer.
// Define PAD_SEQ_HOLD_EN to add a hold input that stalls the stream behind a one-entry read skid.
module pad_window_sequencer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef PAD_SEQ_HOLD_EN
  input  logic              hold,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [1:0]        c,
  output logic [PIX_W-1:0]  pix,
  output logic              col_valid,
  output logic [ADDR_W-1:0] out_row,
  output logic [ADDR_W-1:0] out_col,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [ADDR_W-1:0] row_reg, x_reg, base_reg;
  logic [1:0]        ph_reg;
  logic              stall, issue, pad_col, pad_beat, col_end, frame_end;
  logic [1:0]        code_n;
  logic [ADDR_W-1:0] addr_n;

  logic              mem_rd_en_reg, valid_a_reg, real_a_reg, end_a_reg;
  logic [ADDR_W-1:0] mem_addr_reg, row_a_reg, col_a_reg;
  logic [1:0]        code_a_reg;
  logic              valid_b_reg, real_b_reg, end_b_reg;
  logic [1:0]        c_reg;
  logic [ADDR_W-1:0] row_b_reg, col_b_reg;
  logic              col_valid_reg;
  logic [ADDR_W-1:0] out_row_reg, out_col_reg;

`ifdef PAD_SEQ_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  // Beat about to be issued: code, pad decision and row-relative address.
  always_comb begin
    pad_col   = (x_reg == '0) || (x_reg == X_LAST);
    code_n    = 2'b11;
    pad_beat  = 1'b1;
    addr_n    = base_reg + x_reg - ONE_A;
    if (!pad_col) begin
      case (ph_reg)
        2'd0: begin
          code_n   = 2'b00;
          addr_n   = base_reg + x_reg - ONE_A - W_A;
          pad_beat = (row_reg == '0);
        end
        2'd1: begin
          code_n   = 2'b10;
          pad_beat = 1'b0;
        end
        default: begin
          code_n   = 2'b01;
          addr_n   = base_reg + x_reg - ONE_A + W_A;
          pad_beat = (row_reg == ROW_LAST);
        end
      endcase
    end
    col_end   = pad_col || (ph_reg == 2'd2);
    frame_end = (x_reg == X_LAST) && (row_reg == ROW_LAST);
  end

  always_comb begin
    issue      = (state_reg == S_RUN) && !stall;
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (issue && frame_end) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (col_valid_reg && !valid_a_reg && !valid_b_reg) state_next = S_DONE;
      end
      default: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      x_reg     <= '0;
      ph_reg    <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE) begin
        row_reg  <= '0;
        x_reg    <= '0;
        ph_reg   <= '0;
        base_reg <= '0;
      end else if (issue) begin
        if (col_end) begin
          ph_reg <= '0;
          if (x_reg == X_LAST) begin
            x_reg    <= '0;
            row_reg  <= row_reg + ONE_A;
            base_reg <= base_reg + W_A;
          end else begin
            x_reg <= x_reg + ONE_A;
          end
        end else begin
          ph_reg <= ph_reg + 2'd1;
        end
      end
    end
  end

  // Three-stage pipe: A = address issue, B = beat presented, C = column complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en_reg <= 1'b0;
      mem_addr_reg  <= '0;
      valid_a_reg   <= 1'b0;
      real_a_reg    <= 1'b0;
      end_a_reg     <= 1'b0;
      code_a_reg    <= 2'b11;
      row_a_reg     <= '0;
      col_a_reg     <= '0;
      valid_b_reg   <= 1'b0;
      real_b_reg    <= 1'b0;
      end_b_reg     <= 1'b0;
      c_reg         <= 2'b11;
      row_b_reg     <= '0;
      col_b_reg     <= '0;
      col_valid_reg <= 1'b0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
    end else begin
      mem_rd_en_reg <= issue && !pad_beat;
      if (issue && !pad_beat) mem_addr_reg <= addr_n;
      col_valid_reg <= !stall && valid_b_reg && end_b_reg;
      if (!stall) begin
        valid_a_reg <= issue;
        real_a_reg  <= issue && !pad_beat;
        end_a_reg   <= col_end;
        code_a_reg  <= code_n;
        row_a_reg   <= row_reg;
        col_a_reg   <= x_reg;
        valid_b_reg <= valid_a_reg;
        real_b_reg  <= valid_a_reg && real_a_reg;
        end_b_reg   <= valid_a_reg && end_a_reg;
        c_reg       <= valid_a_reg ? code_a_reg : 2'b11;
        row_b_reg   <= row_a_reg;
        col_b_reg   <= col_a_reg;
        if (valid_b_reg && end_b_reg) begin
          out_row_reg <= row_b_reg;
          out_col_reg <= col_b_reg;
        end
      end
    end
  end

`ifdef PAD_SEQ_HOLD_EN
  logic             skid_cap_reg, skid_full_reg, b_skid_reg, frozen_reg;
  logic [PIX_W-1:0] skid_reg, pix_frz_reg, pix_live;

  // A read that lands while its beat is stalled in stage A is parked in the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_cap_reg  <= 1'b0;
      skid_full_reg <= 1'b0;
      b_skid_reg    <= 1'b0;
      frozen_reg    <= 1'b0;
      skid_reg      <= '0;
      pix_frz_reg   <= '0;
    end else begin
      skid_cap_reg <= stall && mem_rd_en_reg;
      if (skid_cap_reg) skid_reg <= mem_data;
      if (stall) begin
        skid_full_reg <= skid_full_reg || skid_cap_reg;
      end else begin
        skid_full_reg <= 1'b0;
        b_skid_reg    <= skid_full_reg || skid_cap_reg;
      end
      frozen_reg  <= stall;
      pix_frz_reg <= pix;
    end
  end

  assign pix_live = real_b_reg ? (b_skid_reg ? skid_reg : mem_data) : '0;
  assign pix      = frozen_reg ? pix_frz_reg : pix_live;
`else
  assign pix = real_b_reg ? mem_data : '0;
`endif

  assign mem_rd_en = mem_rd_en_reg;
  assign mem_addr  = mem_addr_reg;
  assign c         = c_reg;
  assign col_valid = col_valid_reg;
  assign out_row   = out_row_reg;
  assign out_col   = out_col_reg;
endmodule

// File: tb/tb_pad_window_sequencer.sv
// Bench for pad_window_sequencer: RAM and column-buffer models plus a window reference model.
`timescale 1ns/1ps
module tb_pad_window_sequencer;
  localparam int W = 4, H = 3, AW = 10, PW = 8;
  localparam int NCOL  = H * (W + 2);
  localparam int NBEAT = H * (3 * W + 2);

  logic clk = 1'b0;
  logic rst, start, hold;
  logic mem_rd_en, col_valid, busy, done;
  logic [AW-1:0] mem_addr, out_row, out_col;
  logic [PW-1:0] mem_data = '0;
  logic [PW-1:0] pix;
  logic [1:0] c;

  always #5 clk = ~clk;

  pad_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef PAD_SEQ_HOLD_EN
    .hold(hold),
`endif
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .c(c), .pix(pix), .col_valid(col_valid), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  logic [PW-1:0] ram [0:W*H-1];
  always @(posedge clk) if (mem_rd_en) mem_data <= ram[mem_addr];

  // Column buffer: each beat code writes one byte of the window column, 11 clears it.
  logic [23:0] p = '0;
  always @(posedge clk) begin
    case (c)
      2'b00:   p[23:16] <= pix;
      2'b10:   p[15:8]  <= pix;
      2'b01:   p[7:0]   <= pix;
      default: p        <= '0;
    endcase
  end

  typedef struct { int addr; logic [1:0] code; } rd_t;
  typedef struct { int r; int x; logic [23:0] p; } col_t;
  rd_t  exp_rd[$];
  col_t exp_col[$];
  logic [23:0] cap_p [0:H-1][0:W+1];

  int checks = 0, errors = 0;
  int rd_idx, col_idx, cyc = 0, first_cv, last_cv, dones;
  logic mon_en = 1'b0, hold_frame = 1'b0, prev_rd = 1'b0, prev_hold = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [1:0] prev_code = 2'b11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every window column and every RAM read of a frame, straight from the padding rules.
  task automatic build_model();
    exp_rd.delete();
    exp_col.delete();
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W + 2; x++) begin
        logic [23:0] v;
        v = '0;
        if (x >= 1 && x <= W) begin
          for (int k = 0; k < 3; k++) begin
            int rr;
            rr = r - 1 + k;
            if (rr >= 0 && rr < H) begin
              exp_rd.push_back('{rr * W + x - 1, (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b01});
              v[23 - 8 * k -: 8] = ram[rr * W + x - 1];
            end
          end
        end
        exp_col.push_back('{r, x, v});
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (prev_rd && !prev_hold) begin
        chk("beat_code", c, prev_code);
        chk("beat_pix", pix, ram[prev_addr]);
      end
      if (mem_rd_en) begin
        if (rd_idx < exp_rd.size()) begin
          chk("rd_addr", mem_addr, exp_rd[rd_idx].addr);
          prev_code = exp_rd[rd_idx].code;
        end else begin
          checks++; errors++;
          $display("FAIL extra_read: got addr %0d with %0d reads required", mem_addr, exp_rd.size());
          prev_code = 2'b11;
        end
        rd_idx++;
      end
      if (col_valid) begin
        if (col_idx < exp_col.size()) begin
          chk("col_row", out_row, exp_col[col_idx].r);
          chk("col_col", out_col, exp_col[col_idx].x);
          chk("col_p", p, exp_col[col_idx].p);
          cap_p[exp_col[col_idx].r][exp_col[col_idx].x] = p;
          $display("col %0d: row=%0d col=%0d p=%06h", col_idx, out_row, out_col, p);
        end else begin
          checks++; errors++;
          $display("FAIL extra_col: got col_valid number %0d with %0d required", col_idx + 1, NCOL);
        end
        if (col_idx == 0) first_cv = cyc;
        last_cv = cyc;
        col_idx++;
      end
      if (done) begin
        chk("done_cols", col_idx, NCOL);
        chk("done_reads", rd_idx, exp_rd.size());
        chk("done_gap", cyc - last_cv, 1);
        chk("done_busy", busy, 0);
        if (!hold_frame) chk("beat_span", last_cv - first_cv, NBEAT - 1);
        $display("done: cols=%0d reads=%0d", col_idx, rd_idx);
        dones++;
      end
    end
    prev_rd   = mem_rd_en;
    prev_addr = mem_addr;
    prev_hold = hold;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input bit extra_start, input bit use_hold);
    int n;
    build_model();
    rd_idx = 0; col_idx = 0; dones = 0; mon_en = 1'b1; hold_frame = use_hold;
    pulse_start();
    n = 0;
    while (dones == 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (extra_start) start = (n == 20);
      if (use_hold) hold = (n >= 30 && n < 33) || (n > 40 && $urandom_range(0, 3) == 0);
    end
    start = 1'b0; hold = 1'b0;
    if (dones == 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got no done after %0d cycles, required done", n);
    end
    repeat (10) @(posedge clk);
    #1 chk("idle_after_frame", busy, 0);
    chk("single_done", dones, 1);
  endtask

  typedef struct { int r; int x; logic [23:0] p; } vec_t;
  vec_t vecs[4];

  initial begin
    int n, seen;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    for (int i = 0; i < W * H; i++) ram[i] = PW'(i + 1);
    vecs[0] = '{0, 1, 24'h000105};
    vecs[1] = '{2, 4, {8'd8, 8'd12, 8'd0}};
    vecs[2] = '{1, 0, 24'h000000};
    vecs[3] = '{1, 5, 24'h000000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_c", c, 2'b11);
    chk("rst_pix", pix, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Counting frame, with a start pulse while busy that must be ignored.
    run_frame(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("table_p", cap_p[vecs[i].r][vecs[i].x], vecs[i].p);

    // Reset in the middle of row 1.
    build_model();
    rd_idx = 0; col_idx = 0; dones = 0; mon_en = 1'b1; hold_frame = 1'b0;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(col_valid && out_row == 1 && out_col == 2) && n < 500);
    chk("abort_point_found", n < 500, 1);
    @(posedge clk); #1 rst = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_c", c, 2'b11);
    chk("abort_pix", pix, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_col_valid", col_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_row", out_row, 0);
    chk("abort_out_col", out_col, 0);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Fresh start replays the frame from row 0.
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("replay_table_p", cap_p[vecs[i].r][vecs[i].x], vecs[i].p);

    // Random image content.
    for (int i = 0; i < W * H; i++) ram[i] = PW'($urandom);
    run_frame(1'b0, 1'b0);

`ifdef PAD_SEQ_HOLD_EN
    for (int i = 0; i < W * H; i++) ram[i] = PW'($urandom);
    run_frame(1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
